// File: rtl/snitch_icache_refill_ctrl.sv
// Instruction-cache miss handler: merges misses into a small pending table, issues line
// refills, writes returned lines into the lookup RAMs (round-robin way) and answers requesters.
module snitch_icache_refill_ctrl #(
   parameter int unsigned FETCH_AW      = 32,
   parameter int unsigned LINE_WIDTH    = 128,
   parameter int unsigned LINE_ALIGN    = 4,
   parameter int unsigned COUNT_ALIGN   = 5,
   parameter int unsigned SET_COUNT     = 4,
   parameter int unsigned SET_ALIGN     = 2,
   parameter int unsigned TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
   parameter int unsigned ID_WIDTH      = 4,
   parameter int unsigned PENDING_COUNT = 2,
   parameter int unsigned PID_WIDTH     = $clog2(PENDING_COUNT)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_valid_i,
   output logic                   flush_ready_o,
   input  logic [FETCH_AW-1:0]    miss_addr_i,
   input  logic [ID_WIDTH-1:0]    miss_id_i,
   input  logic                   miss_valid_i,
   output logic                   miss_ready_o,
   output logic [FETCH_AW-1:0]    refill_addr_o,
   output logic [PID_WIDTH-1:0]   refill_pid_o,
   output logic                   refill_valid_o,
   input  logic                   refill_ready_i,
   input  logic [LINE_WIDTH-1:0]  refill_data_i,
   input  logic                   refill_error_i,
   input  logic [PID_WIDTH-1:0]   refill_pid_i,
   input  logic                   refill_rvalid_i,
   output logic                   refill_rready_o,
   output logic [COUNT_ALIGN-1:0] write_addr_o,
   output logic [SET_ALIGN-1:0]   write_set_o,
   output logic [LINE_WIDTH-1:0]  write_data_o,
   output logic [TAG_WIDTH-1:0]   write_tag_o,
   output logic                   write_error_o,
   output logic                   write_valid_o,
   input  logic                   write_ready_i,
   output logic [LINE_WIDTH-1:0]  out_data_o,
   output logic [ID_WIDTH-1:0]    out_id_o,
   output logic                   out_error_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i
);
   localparam int unsigned LineW = FETCH_AW - LINE_ALIGN;

   typedef enum logic {WaitIssue, WaitRsp} entry_state_e;
   typedef enum logic [1:0] {StIdle, StWrite, StResp} rsp_state_e;

   logic [PENDING_COUNT-1:0] valid_q, valid_d;
   entry_state_e             state_q [PENDING_COUNT];
   entry_state_e             state_d [PENDING_COUNT];
   logic [LineW-1:0]         line_q  [PENDING_COUNT];
   logic [LineW-1:0]         line_d  [PENDING_COUNT];
   logic [ID_WIDTH-1:0]      id_q    [PENDING_COUNT];
   logic [ID_WIDTH-1:0]      id_d    [PENDING_COUNT];

   rsp_state_e            rsp_q, rsp_d;
   logic [PID_WIDTH-1:0]  rsp_pid_q, rsp_pid_d;
   logic [LineW-1:0]      rsp_line_q, rsp_line_d;
   logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
   logic [SET_ALIGN-1:0]  victim_q, victim_d;

   logic [LineW-1:0]     miss_line;
   logic                 merge_hit, free_hit, issue_hit;
   logic [PID_WIDTH-1:0] merge_idx, free_idx, issue_idx;
   logic                 unused_miss_offset;

   assign miss_line          = miss_addr_i[FETCH_AW-1:LINE_ALIGN];
   assign unused_miss_offset = ^miss_addr_i[LINE_ALIGN-1:0];

   // The entry owned by the response FSM no longer accepts merges: its IDs are already committed.
   always_comb begin
      merge_hit = 1'b0;
      merge_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
      issue_hit = 1'b0;
      issue_idx = '0;
      for (int i = 0; i < PENDING_COUNT; i++) begin
         if (valid_q[i] && (line_q[i] == miss_line) && !merge_hit &&
             !((rsp_q != StIdle) && (rsp_pid_q == PID_WIDTH'(i)))) begin
            merge_hit = 1'b1;
            merge_idx = PID_WIDTH'(i);
         end
         if (!valid_q[i] && !free_hit) begin
            free_hit = 1'b1;
            free_idx = PID_WIDTH'(i);
         end
         if (valid_q[i] && (state_q[i] == WaitIssue) && !issue_hit) begin
            issue_hit = 1'b1;
            issue_idx = PID_WIDTH'(i);
         end
      end
   end

   assign miss_ready_o   = !flush_valid_i && (merge_hit || free_hit);
   assign refill_valid_o = issue_hit;
   assign refill_pid_o   = issue_idx;
   assign refill_addr_o  = issue_hit ? {line_q[issue_idx], {LINE_ALIGN{1'b0}}} : '0;
   assign flush_ready_o  = flush_valid_i && (valid_q == '0) && (rsp_q == StIdle);

   always_comb begin
      valid_d = valid_q;
      state_d = state_q;
      line_d  = line_q;
      id_d    = id_q;
      if (refill_valid_o && refill_ready_i) begin
         state_d[issue_idx] = WaitRsp;
      end
      if (miss_valid_i && miss_ready_o) begin
         if (merge_hit) begin
            id_d[merge_idx] = id_q[merge_idx] | miss_id_i;
         end else begin
            valid_d[free_idx] = 1'b1;
            state_d[free_idx] = WaitIssue;
            line_d[free_idx]  = miss_line;
            id_d[free_idx]    = miss_id_i;
         end
      end
      // Allocation looks at valid_q, so a slot freed here is not reused in the same cycle.
      if (out_valid_o && out_ready_i) begin
         valid_d[rsp_pid_q] = 1'b0;
      end
   end

   always_comb begin
      rsp_d           = rsp_q;
      rsp_pid_d       = rsp_pid_q;
      rsp_line_d      = rsp_line_q;
      rsp_data_d      = rsp_data_q;
      rsp_err_d       = rsp_err_q;
      out_id_d        = out_id_q;
      victim_d        = victim_q;
      refill_rready_o = (rsp_q == StIdle);
      write_valid_o   = (rsp_q == StWrite);
      out_valid_o     = (rsp_q == StResp);
      unique case (rsp_q)
         StIdle: begin
            if (refill_rvalid_i) begin
               rsp_pid_d  = refill_pid_i;
               rsp_line_d = line_q[refill_pid_i];
               rsp_data_d = refill_data_i;
               rsp_err_d  = refill_error_i;
               rsp_d      = StWrite;
            end
         end
         StWrite: begin
            if (write_ready_i) begin
               victim_d = (victim_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : victim_q + 1'b1;
               out_id_d = id_q[rsp_pid_q];
               rsp_d    = StResp;
            end
         end
         StResp: begin
            if (out_ready_i) begin
               rsp_d = StIdle;
            end
         end
         default: rsp_d = StIdle;
      endcase
   end

   assign write_addr_o  = rsp_line_q[COUNT_ALIGN-1:0];
   assign write_tag_o   = rsp_line_q[LineW-1:COUNT_ALIGN];
   assign write_set_o   = victim_q;
   assign write_data_o  = rsp_data_q;
   assign write_error_o = rsp_err_q;
   assign out_data_o    = rsp_data_q;
   assign out_id_o      = out_id_q;
   assign out_error_o   = rsp_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= '0;
         rsp_q      <= StIdle;
         rsp_pid_q  <= '0;
         rsp_line_q <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         out_id_q   <= '0;
         victim_q   <= '0;
         for (int i = 0; i < PENDING_COUNT; i++) begin
            state_q[i] <= WaitIssue;
            line_q[i]  <= '0;
            id_q[i]    <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         state_q    <= state_d;
         line_q     <= line_d;
         id_q       <= id_d;
         rsp_q      <= rsp_d;
         rsp_pid_q  <= rsp_pid_d;
         rsp_line_q <= rsp_line_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         out_id_q   <= out_id_d;
         victim_q   <= victim_d;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (refill_rvalid_i && refill_rready_o) |->
         (valid_q[refill_pid_i] && (state_q[refill_pid_i] == WaitRsp)));

endmodule
